// File: rtl/sram_arb_pkg.sv
// Shared encodings for the SRAM front-end arbiter: FSM states, access sizes,
// port select, default timing parameters and the alignment check.
package sram_arb_pkg;

    localparam logic [2:0] ST_RST_HOLD = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_ISSUE_LO = 3'd2;
    localparam logic [2:0] ST_WAIT_LO  = 3'd3;
    localparam logic [2:0] ST_ISSUE_HI = 3'd4;
    localparam logic [2:0] ST_WAIT_HI  = 3'd5;
    localparam logic [2:0] ST_RESP     = 3'd6;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_e;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_QUIESCE      = 6;

    function automatic logic is_legal(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Port selection between fetch and data. With SRAM_ARB_STARVE_EN defined a
// starvation counter lets fetch win after STARVE_LIMIT contested data grants.
module sram_arb_grant
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_req,
    input  logic d_req,
    input  logic grant,
    output logic sel
);

`ifdef SRAM_ARB_STARVE_EN
    logic [3:0] starve_cnt;
    logic       starved;

    assign starved = (starve_cnt >= 4'(STARVE_LIMIT));
    assign sel     = (d_req && !(i_req && starved)) ? PORT_D :
                     (i_req ? PORT_I : PORT_D);

    // Only data grants taken while fetch waits count toward starvation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (sel == PORT_I) begin
                starve_cnt <= '0;
            end else if (i_req) begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
`else
    logic unused_ok;

    assign sel       = (i_req && !d_req) ? PORT_I : PORT_D;
    assign unused_ok = ^{clk, rst_n, grant, STARVE_LIMIT};
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates fetch and load/store onto one 16-bit SRAM front end, splitting
// word accesses into LO/HI halves. Optional starvation guard: SRAM_ARB_STARVE_EN.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int QUIESCE      = DEF_QUIESCE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic        i_err,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_rw,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_valid,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_done,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    // Handshake: a requester holds req and its fields until it sees a one-cycle
    // ack/err and drops req on the next edge; the front end gets a one-cycle
    // mem_valid with fields held until mem_done, which is only honoured in WAIT_*.

    logic [2:0]  state;
    logic [7:0]  q_cnt;
    port_e       sel_q;
    logic        err_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [15:0] wdata_hi_q;
    logic [31:0] rdata_q;

    logic        gnt_sel;
    logic        grant_stb;
    port_e       req_port;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [15:0] req_lo_wdata;
    logic        req_ok;
    logic [31:0] lo_rdata;
    logic        resp_ok;

    assign grant_stb = (state == ST_IDLE) && (i_req || d_req);

    sram_arb_grant #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_grant (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (i_req),
        .d_req (d_req),
        .grant (grant_stb),
        .sel   (gnt_sel)
    );

    always_comb begin
        req_port  = port_e'(gnt_sel);
        req_rw    = 1'b0;
        req_size  = SZ_WORD;
        req_addr  = i_addr;
        req_wdata = '0;
        if (req_port == PORT_D) begin
            req_rw    = d_rw;
            req_size  = d_size;
            req_addr  = d_addr;
            req_wdata = d_wdata;
        end
        req_lo_wdata = (req_size == SZ_BYTE) ? {req_wdata[7:0], req_wdata[7:0]} : req_wdata[15:0];
        req_ok       = is_legal(req_size, req_addr[1:0]);
    end

    // Byte reads pick the lane selected by addr[0]; everything else is right-aligned.
    always_comb begin
        lo_rdata = {16'h0000, mem_rdata};
        if (size_q == SZ_BYTE) begin
            lo_rdata = {24'h000000, (addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0])};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_RST_HOLD;
            q_cnt      <= '0;
            sel_q      <= PORT_I;
            err_q      <= 1'b0;
            size_q     <= SZ_BYTE;
            addr_q     <= '0;
            wdata_hi_q <= '0;
            rdata_q    <= '0;
            mem_rw     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                ST_RST_HOLD: begin
                    if (q_cnt == 8'(QUIESCE - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        q_cnt <= q_cnt + 8'd1;
                    end
                end
                ST_IDLE: begin
                    if (grant_stb) begin
                        sel_q      <= req_port;
                        size_q     <= req_size;
                        addr_q     <= req_addr;
                        wdata_hi_q <= req_wdata[31:16];
                        rdata_q    <= '0;
                        if (req_ok) begin
                            err_q     <= 1'b0;
                            mem_rw    <= req_rw;
                            mem_addr  <= req_addr;
                            mem_wdata <= req_lo_wdata;
                            state     <= ST_ISSUE_LO;
                        end else begin
                            err_q <= 1'b1;
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE_LO: state <= ST_WAIT_LO;
                ST_WAIT_LO: begin
                    if (mem_done) begin
                        rdata_q <= lo_rdata;
                        if (size_q == SZ_WORD) begin
                            mem_addr  <= addr_q + 32'd2;
                            mem_wdata <= wdata_hi_q;
                            state     <= ST_ISSUE_HI;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE_HI: state <= ST_WAIT_HI;
                ST_WAIT_HI: begin
                    if (mem_done) begin
                        rdata_q[31:16] <= mem_rdata;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign resp_ok   = (state == ST_RESP) && !err_q;
    assign i_ack     = resp_ok && (sel_q == PORT_I);
    assign d_ack     = resp_ok && (sel_q == PORT_D);
    assign i_err     = (state == ST_RESP) && err_q && (sel_q == PORT_I);
    assign d_err     = (state == ST_RESP) && err_q && (sel_q == PORT_D);
    assign i_rdata   = i_ack ? rdata_q : '0;
    assign d_rdata   = d_ack ? rdata_q : '0;
    assign mem_valid = (state == ST_ISSUE_LO) || (state == ST_ISSUE_HI);
    // Busy covers an accepted request only, so the post-reset hold reads as 0.
    assign busy      = (state != ST_IDLE) && (state != ST_RST_HOLD);
    assign state_dbg = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table, starvation sequence and a
// reset-during-WAIT_HI sequence against a 4-cycle front-end model.
module tb_sram_arbiter;
    import sram_arb_pkg::*;

    localparam int QUIESCE      = 6;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        logic        port;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] rd0;
        logic [15:0] rd1;
        logic        exp_err;
        int          exp_cyc;
        logic [31:0] exp_rdata;
        int          exp_ntx;
        logic [31:0] exp_a0;
        logic [15:0] exp_w0;
        logic [31:0] exp_a1;
        logic [15:0] exp_w1;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic        i_ack, i_err;
    logic [31:0] i_rdata;
    logic        d_req = 1'b0;
    logic        d_rw = 1'b0;
    logic [1:0]  d_size = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        mem_valid, mem_rw;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        mem_done = 1'b0;
    logic        busy;
    logic [2:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] log_addr[$];
    logic [15:0] log_wdata[$];
    logic        log_rw[$];
    logic [15:0] fe_rd_q[$];
    int          mv_long = 0;
    logic        mv_prev = 1'b0;

    always #5 clk = ~clk;

    sram_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .QUIESCE     (QUIESCE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_ack     (i_ack),
        .i_err     (i_err),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_rw      (d_rw),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_ack     (d_ack),
        .d_err     (d_err),
        .d_rdata   (d_rdata),
        .mem_valid (mem_valid),
        .mem_rw    (mem_rw),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // Front-end model: logs each transaction, answers mem_done 4 cycles after mem_valid.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_valid) begin
                log_addr.push_back(mem_addr);
                log_wdata.push_back(mem_wdata);
                log_rw.push_back(mem_rw);
                repeat (4) @(posedge clk);
                #1;
                mem_rdata = 16'h0000;
                if (fe_rd_q.size() > 0) mem_rdata = fe_rd_q.pop_front();
                mem_done = 1'b1;
                @(posedge clk);
                #1;
                mem_done = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mem_valid && mv_prev) mv_long++;
        mv_prev = mem_valid;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_wdata.delete();
        log_rw.delete();
    endtask

    task automatic do_req(input vec_t v, output logic got_ack, output logic got_err,
                          output logic bad_port, output logic busy1, output int cyc,
                          output logic [31:0] rdata);
        logic done;
        got_ack = 1'b0; got_err = 1'b0; bad_port = 1'b0; busy1 = 1'b0;
        cyc = -1; rdata = '0; done = 1'b0;
        if (v.port) begin
            d_req = 1'b1; d_rw = v.rw; d_size = v.size; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (c == 1) busy1 = busy;
            if (v.port) begin
                if (d_ack || d_err) begin
                    got_ack = d_ack; got_err = d_err; rdata = d_rdata; cyc = c; done = 1'b1;
                end
                if (i_ack || i_err) bad_port = 1'b1;
            end else begin
                if (i_ack || i_err) begin
                    got_ack = i_ack; got_err = i_err; rdata = i_rdata; cyc = c; done = 1'b1;
                end
                if (d_ack || d_err) bad_port = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        vec_t        vecs[13];
        logic        got_ack, got_err, bad_port, busy1, found;
        int          cyc, n, mv_cyc, dack_cyc, ia_seen;
        logic [31:0] rdata;
        logic [9:0]  order, exp_order;
        string       nm;

        //           port rw size     addr          wdata         rd0       rd1       err cyc rdata         ntx a0            w0        a1            w1
        vecs[0]  = '{1'b0, 1'b0, SZ_WORD, 32'h0000_0100, 32'h0,         16'h1111, 16'h2222, 1'b0, 11, 32'h2222_1111, 2, 32'h0000_0100, 16'h0,    32'h0000_0102, 16'h0};
        vecs[1]  = '{1'b1, 1'b1, SZ_BYTE, 32'h0000_0205, 32'h0000_00AB, 16'h0,    16'h0,    1'b0, 6,  32'h0,         1, 32'h0000_0205, 16'hABAB, 32'h0,         16'h0};
        vecs[2]  = '{1'b1, 1'b0, SZ_HALF, 32'h0000_0301, 32'h0,         16'h0,    16'h0,    1'b1, 1,  32'h0,         0, 32'h0,         16'h0,    32'h0,         16'h0};
        vecs[3]  = '{1'b1, 1'b0, SZ_BYTE, 32'h0000_0207, 32'h0,         16'h5A3C, 16'h0,    1'b0, 6,  32'h0000_005A, 1, 32'h0000_0207, 16'h0,    32'h0,         16'h0};
        vecs[4]  = '{1'b1, 1'b0, SZ_BYTE, 32'h0000_0206, 32'h0,         16'h5A3C, 16'h0,    1'b0, 6,  32'h0000_003C, 1, 32'h0000_0206, 16'h0,    32'h0,         16'h0};
        vecs[5]  = '{1'b1, 1'b0, SZ_HALF, 32'h0000_0402, 32'h0,         16'hBEEF, 16'h0,    1'b0, 6,  32'h0000_BEEF, 1, 32'h0000_0402, 16'h0,    32'h0,         16'h0};
        vecs[6]  = '{1'b1, 1'b1, SZ_WORD, 32'hFFFF_FFFC, 32'hCAFE_F00D, 16'h0,    16'h0,    1'b0, 11, 32'h0,         2, 32'hFFFF_FFFC, 16'hF00D, 32'hFFFF_FFFE, 16'hCAFE};
        vecs[7]  = '{1'b1, 1'b0, 2'b11,   32'h0000_0000, 32'h0,         16'h0,    16'h0,    1'b1, 1,  32'h0,         0, 32'h0,         16'h0,    32'h0,         16'h0};
        vecs[8]  = '{1'b1, 1'b0, SZ_WORD, 32'h0000_0102, 32'h0,         16'h0,    16'h0,    1'b1, 1,  32'h0,         0, 32'h0,         16'h0,    32'h0,         16'h0};
        vecs[9]  = '{1'b0, 1'b0, SZ_WORD, 32'h0000_0101, 32'h0,         16'h0,    16'h0,    1'b1, 1,  32'h0,         0, 32'h0,         16'h0,    32'h0,         16'h0};
        vecs[10] = '{1'b1, 1'b0, SZ_WORD, 32'h0000_0500, 32'h0,         16'h3344, 16'h1122, 1'b0, 11, 32'h1122_3344, 2, 32'h0000_0500, 16'h0,    32'h0000_0502, 16'h0};
        vecs[11] = '{1'b1, 1'b1, SZ_HALF, 32'h0000_0600, 32'h1234_5678, 16'h0,    16'h0,    1'b0, 6,  32'h0,         1, 32'h0000_0600, 16'h5678, 32'h0,         16'h0};
        vecs[12] = '{1'b0, 1'b0, SZ_WORD, 32'hFFFF_FFFC, 32'h0,         16'hAAAA, 16'h5555, 1'b0, 11, 32'h5555_AAAA, 2, 32'hFFFF_FFFC, 16'h0,    32'hFFFF_FFFE, 16'h0};

        // Reset values
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {i_ack, i_err, d_ack, d_err, mem_valid, mem_rw, busy}, 32'h0);
        check("reset_mem_addr", mem_addr, 32'h0);
        check("reset_rdata", i_rdata | d_rdata | {16'h0, mem_wdata}, 32'h0);
        check("reset_state", {29'h0, state_dbg}, {29'h0, ST_RST_HOLD});
        rst_n = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            @(posedge clk);
            #1;
            if (state_dbg == ST_IDLE) found = 1'b1;
        end
        check("reset_reach_idle", {31'h0, found}, 32'h1);

        // Vector table
        for (int k = 0; k < 13; k++) begin
            clear_logs();
            fe_rd_q.delete();
            fe_rd_q.push_back(vecs[k].rd0);
            fe_rd_q.push_back(vecs[k].rd1);
            do_req(vecs[k], got_ack, got_err, bad_port, busy1, cyc, rdata);
            nm = $sformatf("v%0d", k);
            check({nm, "_err"}, {30'h0, got_ack, got_err}, {30'h0, ~vecs[k].exp_err, vecs[k].exp_err});
            check({nm, "_cycle"}, cyc, vecs[k].exp_cyc);
            check({nm, "_other_port"}, {31'h0, bad_port}, 32'h0);
            check({nm, "_busy"}, {31'h0, busy1}, 32'h1);
            check({nm, "_ntx"}, log_addr.size(), vecs[k].exp_ntx);
            if (!vecs[k].exp_err && !vecs[k].rw) check({nm, "_rdata"}, rdata, vecs[k].exp_rdata);
            if (log_addr.size() >= 1 && vecs[k].exp_ntx >= 1) begin
                check({nm, "_a0"}, log_addr[0], vecs[k].exp_a0);
                check({nm, "_rw0"}, {31'h0, log_rw[0]}, {31'h0, vecs[k].rw});
                if (vecs[k].rw) check({nm, "_w0"}, {16'h0, log_wdata[0]}, {16'h0, vecs[k].exp_w0});
            end
            if (log_addr.size() >= 2 && vecs[k].exp_ntx >= 2) begin
                check({nm, "_a1"}, log_addr[1], vecs[k].exp_a1);
                if (vecs[k].rw) check({nm, "_w1"}, {16'h0, log_wdata[1]}, {16'h0, vecs[k].exp_w1});
            end
        end

        // Both ports requesting continuously
        fe_rd_q.delete();
        i_addr = 32'h0000_0000; i_req = 1'b1;
        d_rw = 1'b0; d_size = SZ_BYTE; d_addr = 32'h0000_0010; d_wdata = '0; d_req = 1'b1;
        n = 0;
        order = '0;
`ifdef SRAM_ARB_STARVE_EN
        exp_order = 10'b01111_01111;
`else
        exp_order = 10'b11111_11111;
`endif
        for (int c = 0; c < 400 && n < 10; c++) begin
            @(negedge clk);
            if (i_ack) begin order[n] = 1'b0; n++; end
            else if (d_ack) begin order[n] = 1'b1; n++; end
            @(posedge clk);
            #1;
        end
        i_req = 1'b0;
        d_req = 1'b0;
        check("starve_grant_count", n, 10);
        for (int g = 0; g < 10; g++) begin
            check($sformatf("starve_grant%0d_is_data", g), {31'h0, order[g]}, {31'h0, exp_order[g]});
        end
        @(posedge clk);
        #1;

        // Reset during WAIT_HI
        clear_logs();
        fe_rd_q.delete();
        fe_rd_q.push_back(16'h1111);
        fe_rd_q.push_back(16'h2222);
        i_addr = 32'h0000_0100; i_req = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (state_dbg == ST_WAIT_HI) found = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check("rst_reach_wait_hi", {31'h0, found}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", {i_ack, i_err, d_ack, d_err, mem_valid, mem_rw, busy}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", {16'h0, mem_wdata}, 32'h0);
        i_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        clear_logs();
        d_req = 1'b1; d_rw = 1'b1; d_size = SZ_BYTE; d_addr = 32'h0000_0205; d_wdata = 32'h0000_0055;
        mv_cyc = -1; dack_cyc = -1; ia_seen = 0;
        for (int c = 0; c < 40 && dack_cyc < 0; c++) begin
            @(negedge clk);
            if (i_ack || i_err) ia_seen++;
            if (mem_valid && mv_cyc < 0) mv_cyc = c;
            if (d_ack) dack_cyc = c;
            @(posedge clk);
            #1;
        end
        d_req = 1'b0;
        check("rst_no_fetch_ack", ia_seen, 0);
        check("rst_quiesce_gap", {31'h0, (mv_cyc > QUIESCE)}, 32'h1);
        check("rst_d_ack_latency", dack_cyc, mv_cyc + 5);
        check("rst_ntx", log_addr.size(), 1);
        if (log_addr.size() >= 1) begin
            check("rst_a0", log_addr[0], 32'h0000_0205);
            check("rst_w0", {16'h0, log_wdata[0]}, 32'h0000_5555);
        end
        check("mem_valid_width", mv_long, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
